mesh_traffic_injector: RTL and testbench
========================================

Name: mesh_traffic_injector

Overview:
- Parametrised, synthesizable traffic source for the router mesh. It replaces hand-written per-node stimulus in mesh testbenches and on-chip self-test.
- Each of the MESH_X*MESH_Y channels injects a configured number of packets into its local router injection port, using a valid/ready handshake.
- Destination is chosen by a run-time mode. Inter-packet gap is programmable. A global FSM reports busy/done and counts accepted packets.
- Sits in the router clock domain, beside mesh_with_controller.

Parameters:
- MESH_X, 4, mesh columns.
- MESH_Y, 4, mesh rows.
- FLIT_W, 32, injected flit width; must be >= 2*NODE_W+CNT_W.
- CNT_W, 8, width of the packets-per-node count and of the sequence number.
- GAP_W, 4, width of the inter-packet idle gap.
- SEED, 16'hACE1, base LFSR seed; channel i uses SEED^i, forced to 1 if the result is 0.
- Derived: NUM_NODES=MESH_X*MESH_Y, NODE_W=max(1,$clog2(NUM_NODES)), TOT_W=CNT_W+NODE_W.

Ports:
- rt_clk  in  1  router clock.
- rt_reset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- mode  in  2  destination mode: 0 uniform random, 1 fixed, 2 transpose, 3 ring-next.
- fixed_dst  in  NODE_W  destination for mode 1.
- pkts_per_node  in  CNT_W  packets each channel sends.
- gap  in  GAP_W  idle cycles after each accepted packet.
- out_valid  out  NUM_NODES  per-channel flit valid.
- out_ready  in  NUM_NODES  per-channel router accept.
- out_flit  out  NUM_NODES*FLIT_W  channel i occupies bits [i*FLIT_W +: FLIT_W].
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- total_sent  out  TOT_W  packets accepted in the current or last run.

Behaviour:
- Reset (rt_reset=0, async): FSM to IDLE. out_valid=0, out_flit=0, busy=0, done=0, total_sent=0. All sent/gap counters=0. LFSRs reload their seeds.
- Node index: n = y*MESH_X + x.
- Flit layout: [NODE_W-1:0] dst; [2*NODE_W-1:NODE_W] src=n; next CNT_W bits seq (0-based per channel); remaining upper bits 0.
- FSM states and transitions:
  - IDLE: on start=1, latch mode, fixed_dst, pkts_per_node and gap; clear total_sent and sent counters; go to RUN with busy=1 from the next cycle.
  - RUN: when every channel has sent == latched count and no out_valid is high, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is ignored while in RUN or DONE.
- Channel operation in RUN:
  - If sent < count and gap_cnt == 0 and out_valid == 0, assert out_valid next cycle with the flit computed from the current LFSR, sent and mode.
  - out_valid and out_flit hold stable until out_valid & out_ready.
  - On handshake, in that same edge: sent+1, LFSR steps once, gap_cnt <= gap, out_valid <= 0.
  - gap_cnt decrements to 0. Minimum issue spacing is 2 cycles when gap=0 (valid deasserts for one cycle); gap=g gives g+2.
- Destination by mode:
  - Mode 0: r = LFSR[NODE_W-1:0]; if r >= NUM_NODES then r -= NUM_NODES; if r == n then r = (n+1) mod NUM_NODES.
  - Mode 1: fixed_dst, taken mod NUM_NODES by the same subtract rule.
  - Mode 2: dst = x*MESH_X + y when MESH_X == MESH_Y; otherwise behaves as mode 3.
  - Mode 3: (n+1) mod NUM_NODES.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It never reaches 0.
- total_sent: increments by popcount(out_valid & out_ready) each cycle. The adder is NUM_NODES wide. No overflow is possible within TOT_W.
- pkts_per_node == 0: sequence is IDLE → RUN (1 cycle) → DONE; total_sent=0.
- A reset mid-run drops any held flit (out_valid=0 immediately). Downstream must tolerate the lost packet.

Decomposition:
- Package mesh_pkg holds MODE_* localparams, the flit field offsets/widths, and the LFSR tap constant. It is shared with the router ejection checker.
- One sub-module, injector_channel: per-channel LFSR, sent/gap counters, destination mux and valid/ready hold. It is instantiated NUM_NODES times by a generate loop. The top holds the FSM and total_sent.

Test Plan:
- 2x2, mode 3, pkts=3, gap=0, ready=all 1 → each channel emits seq 0,1,2 to (n+1)%4, 2 cycles apart; done pulses once; total_sent=12; busy falls in the done cycle.
- 4x4, mode 2, pkts=1, ready=1 → node 1 (x1,y0) sends dst=4; node 5 sends dst=5; total_sent=16.
- 2x2, mode 1, fixed_dst=6 (→2), ready[0]=0 for 10 cycles → out_valid[0] held with flit unchanged for 10 cycles; sends on release; other channels unaffected.
- 4x4, mode 0, pkts=255, random ready → no dst equals src; all dst < 16; per-channel seq is contiguous 0..254; total_sent=4080.
- pkts=0 → done exactly 2 cycles after start; out_valid never rises. A start pulsed during a run is ignored (total unchanged).
- Assert rt_reset low mid-run with out_valid[0] high → all outputs 0 asynchronously; after release, a new start gives a clean run from seq 0.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh traffic injector and the router ejection
// checker. This file holds the destination mode encodings, the flit field
// layout helpers, the LFSR polynomial and the FSM state type.
package mesh_pkg;

  // Destination selection modes
  localparam logic [1:0] MODE_UNIFORM   = 2'd0;
  localparam logic [1:0] MODE_FIXED     = 2'd1;
  localparam logic [1:0] MODE_TRANSPOSE = 2'd2;
  localparam logic [1:0] MODE_RING      = 2'd3;

  // 16-bit Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Flit layout: dst at bit 0, src above it, sequence number above src
  localparam int DST_LSB = 0;

  function automatic int src_lsb(input int node_w);
    return node_w;
  endfunction

  function automatic int seq_lsb(input int node_w);
    return 2 * node_w;
  endfunction

  // A node index is at least one bit wide, even for a single-node mesh
  function automatic int node_width(input int num_nodes);
    return (num_nodes <= 1) ? 1 : $clog2(num_nodes);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } inj_state_e;

endpackage

// File: rtl/injector_channel.sv
// One injection channel of the mesh traffic injector.
// Holds the per-channel LFSR, the sent and gap counters, the destination
// mux and the valid/ready hold register for node NODE_IDX.
// Ports:
//   clk_i, rst_ni      router clock, asynchronous active-low reset
//   run_i              global FSM is in RUN; new packets may be issued
//   clear_i            a run is being started; clear sent/gap counters
//   mode_i             latched destination mode
//   fixed_dst_i        latched destination for the fixed mode
//   count_i            latched packets-per-node
//   gap_i              latched idle gap after each accepted packet
//   ready_i            router accepts the offered flit
//   valid_o, flit_o    offered flit
//   finished_o         this channel has sent count_i packets
module injector_channel
  import mesh_pkg::*;
#(
  parameter int          MESH_X    = 4,
  parameter int          MESH_Y    = 4,
  parameter int          FLIT_W    = 32,
  parameter int          CNT_W     = 8,
  parameter int          GAP_W     = 4,
  parameter int          NODE_IDX  = 0,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         NUM_NODES = MESH_X * MESH_Y,
  localparam int         NODE_W    = node_width(NUM_NODES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic [1:0]        mode_i,
  input  logic [NODE_W-1:0] fixed_dst_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [FLIT_W-1:0] flit_o,
  output logic              finished_o
);

  localparam int POS_X   = NODE_IDX % MESH_X;
  localparam int POS_Y   = NODE_IDX / MESH_X;
  localparam int SRC_LSB = src_lsb(NODE_W);
  localparam int SEQ_LSB = seq_lsb(NODE_W);

  localparam logic [NODE_W-1:0] SELF_ID  = NODE_W'(NODE_IDX);
  localparam logic [NODE_W-1:0] NEXT_ID  = NODE_W'((NODE_IDX + 1) % NUM_NODES);
  // Transpose is only defined on a square mesh; elsewhere fall back to ring-next
  localparam logic [NODE_W-1:0] TRANS_ID = (MESH_X == MESH_Y) ?
                                           NODE_W'(POS_X * MESH_X + POS_Y) : NEXT_ID;
  localparam logic [NODE_W:0]   NUM_EXT  = (NODE_W + 1)'(NUM_NODES);

  // Seed of zero would lock the LFSR, so it is replaced by 1
  localparam logic [15:0] SEED_X  = SEED ^ 16'(NODE_IDX);
  localparam logic [15:0] CH_SEED = (SEED_X == 16'd0) ? 16'd1 : SEED_X;

  // 2^NODE_W < 2*NUM_NODES, so one conditional subtract is a full modulo
  function automatic logic [NODE_W-1:0] wrap_node(input logic [NODE_W-1:0] v);
    if ({1'b0, v} >= NUM_EXT) begin
      return v - NUM_EXT[NODE_W-1:0];
    end
    return v;
  endfunction

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              valid_q, valid_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [NODE_W-1:0] rnd_dst;
  logic [NODE_W-1:0] dst;
  logic [FLIT_W-1:0] new_flit;
  logic              handshake;
  logic              issue;

  always_comb begin
    rnd_dst = wrap_node(lfsr_q[NODE_W-1:0]);
    if (rnd_dst == SELF_ID) begin
      rnd_dst = NEXT_ID;
    end
    case (mode_i)
      MODE_UNIFORM:   dst = rnd_dst;
      MODE_FIXED:     dst = wrap_node(fixed_dst_i);
      MODE_TRANSPOSE: dst = TRANS_ID;
      default:        dst = NEXT_ID;
    endcase
  end

  always_comb begin
    new_flit                           = '0;
    new_flit[DST_LSB +: NODE_W]        = dst;
    new_flit[SRC_LSB +: NODE_W]        = SELF_ID;
    new_flit[SEQ_LSB +: CNT_W]         = sent_q;
  end

  assign handshake = valid_q & ready_i;
  assign issue     = run_i && (sent_q < count_i) && (gap_q == '0) && !valid_q;

  always_comb begin
    lfsr_d  = lfsr_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    flit_d  = flit_q;
    if (clear_i) begin
      sent_d = '0;
      gap_d  = '0;
    end else if (handshake) begin
      sent_d  = sent_q + CNT_W'(1);
      lfsr_d  = lfsr_next(lfsr_q);
      gap_d   = gap_i;
      valid_d = 1'b0;
    end else begin
      if (gap_q != '0) begin
        gap_d = gap_q - GAP_W'(1);
      end
      // Flit is captured once and then held until the router takes it
      if (issue) begin
        valid_d = 1'b1;
        flit_d  = new_flit;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q  <= CH_SEED;
      sent_q  <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
    end
  end

  assign valid_o    = valid_q;
  assign flit_o     = flit_q;
  assign finished_o = (sent_q == count_i);

endmodule

// File: rtl/mesh_traffic_injector.sv
// Synthesizable traffic source for the router mesh. Every node gets one
// injector_channel; this top holds the run FSM, the latched run settings
// and the accepted-packet counter.
// Ports:
//   rt_clk, rt_reset   router clock, asynchronous active-low reset
//   start              single-cycle run request (honoured in IDLE only)
//   mode, fixed_dst    destination selection
//   pkts_per_node      packets each channel sends
//   gap                idle cycles after each accepted packet
//   out_valid/out_ready/out_flit  per-channel injection handshake
//   busy, done         run in progress / one-cycle end-of-run pulse
//   total_sent         packets accepted in the current or last run
module mesh_traffic_injector
  import mesh_pkg::*;
#(
  parameter int          MESH_X    = 4,
  parameter int          MESH_Y    = 4,
  parameter int          FLIT_W    = 32,
  parameter int          CNT_W     = 8,
  parameter int          GAP_W     = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         NUM_NODES = MESH_X * MESH_Y,
  localparam int         NODE_W    = node_width(NUM_NODES),
  localparam int         TOT_W     = CNT_W + NODE_W
) (
  input  logic                        rt_clk,
  input  logic                        rt_reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [NODE_W-1:0]           fixed_dst,
  input  logic [CNT_W-1:0]            pkts_per_node,
  input  logic [GAP_W-1:0]            gap,
  output logic [NUM_NODES-1:0]        out_valid,
  input  logic [NUM_NODES-1:0]        out_ready,
  output logic [NUM_NODES*FLIT_W-1:0] out_flit,
  output logic                        busy,
  output logic                        done,
  output logic [TOT_W-1:0]            total_sent
);

  inj_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic [TOT_W-1:0]  total_q;
  logic [1:0]        mode_q;
  logic [NODE_W-1:0] fixed_q;
  logic [CNT_W-1:0]  count_q;
  logic [GAP_W-1:0]  gap_cfg_q;

  logic                 start_acc;
  logic                 run;
  logic [NUM_NODES-1:0] fin;
  logic [NUM_NODES-1:0] hs;
  logic [TOT_W-1:0]     hs_cnt;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign run       = (state_q == ST_RUN);
  assign hs        = out_valid & out_ready;

  always_comb begin
    hs_cnt = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      hs_cnt = hs_cnt + TOT_W'(hs[i]);
    end
  end

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_ch
    injector_channel #(
      .MESH_X   (MESH_X),
      .MESH_Y   (MESH_Y),
      .FLIT_W   (FLIT_W),
      .CNT_W    (CNT_W),
      .GAP_W    (GAP_W),
      .NODE_IDX (i),
      .SEED     (SEED)
    ) u_ch (
      .clk_i       (rt_clk),
      .rst_ni      (rt_reset),
      .run_i       (run),
      .clear_i     (start_acc),
      .mode_i      (mode_q),
      .fixed_dst_i (fixed_q),
      .count_i     (count_q),
      .gap_i       (gap_cfg_q),
      .ready_i     (out_ready[i]),
      .valid_o     (out_valid[i]),
      .flit_o      (out_flit[i*FLIT_W +: FLIT_W]),
      .finished_o  (fin[i])
    );
  end

  always_ff @(posedge rt_clk or negedge rt_reset) begin
    if (!rt_reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      total_q   <= '0;
      mode_q    <= MODE_UNIFORM;
      fixed_q   <= '0;
      count_q   <= '0;
      gap_cfg_q <= '0;
    end else begin
      // Handshakes only occur in RUN, so this add is idle elsewhere
      total_q <= total_q + hs_cnt;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            fixed_q   <= fixed_dst;
            count_q   <= pkts_per_node;
            gap_cfg_q <= gap;
            total_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Wait for the last offered flit to be taken, not just counted
          if ((&fin) && !(|out_valid)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign total_sent = total_q;

endmodule

// File: tb/tb_mesh_traffic_injector.sv
// Testbench for mesh_traffic_injector: a 2x2 instance driven by hand-written
// cycle sequences and a 4x4 instance driven from a table of run settings,
// with a per-handshake flit monitor on the 4x4 instance.
module tb_mesh_traffic_injector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 2x2 instance
  logic         rst2_n, start2;
  logic [1:0]   mode2, fixed2;
  logic [7:0]   pkts2;
  logic [3:0]   gap2;
  logic [3:0]   valid2, ready2;
  logic [127:0] flit2;
  logic         busy2, done2;
  logic [9:0]   total2;

  // 4x4 instance
  logic         rst4_n, start4;
  logic [1:0]   mode4;
  logic [3:0]   fixed4;
  logic [7:0]   pkts4;
  logic [3:0]   gap4;
  logic [15:0]  valid4, ready4;
  logic [511:0] flit4;
  logic         busy4, done4;
  logic [11:0]  total4;

  mesh_traffic_injector #(.MESH_X(2), .MESH_Y(2)) u_dut2 (
    .rt_clk(clk), .rt_reset(rst2_n), .start(start2), .mode(mode2),
    .fixed_dst(fixed2), .pkts_per_node(pkts2), .gap(gap2),
    .out_valid(valid2), .out_ready(ready2), .out_flit(flit2),
    .busy(busy2), .done(done2), .total_sent(total2)
  );

  mesh_traffic_injector #(.MESH_X(4), .MESH_Y(4)) u_dut4 (
    .rt_clk(clk), .rt_reset(rst4_n), .start(start4), .mode(mode4),
    .fixed_dst(fixed4), .pkts_per_node(pkts4), .gap(gap4),
    .out_valid(valid4), .out_ready(ready4), .out_flit(flit4),
    .busy(busy4), .done(done4), .total_sent(total4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 2x2 flit: dst[1:0], src[3:2], seq[11:4]
  function automatic logic [31:0] mk2(input int dst, input int src, input int seq);
    return 32'(dst) | (32'(src) << 2) | (32'(seq) << 4);
  endfunction

  function automatic logic [3:0] exp_dst4(input logic [1:0] md, input logic [3:0] fx, input int n);
    case (md)
      2'd1:    return fx;
      2'd2:    return 4'((n % 4) * 4 + n / 4);
      default: return 4'((n + 1) % 16);
    endcase
  endfunction

  // 4x4 handshake monitor (4x4 flit: dst[3:0], src[7:4], seq[15:8])
  bit          mon_en  = 1'b0;
  bit          was_en  = 1'b0;
  logic [1:0]  cur_mode;
  logic [3:0]  cur_fixed;
  int          seen [16];
  logic [15:0] pv, phs;
  logic [31:0] pf [16];

  always @(negedge clk) begin
    if (mon_en && !was_en) begin
      for (int i = 0; i < 16; i++) seen[i] = 0;
      pv  = '0;
      phs = '0;
    end
    if (mon_en) begin
      for (int i = 0; i < 16; i++) begin
        logic [31:0] f;
        f = flit4[i*32 +: 32];
        if (pv[i] && !phs[i]) begin
          chk($sformatf("hold_valid[%0d]", i), 64'(valid4[i]), 64'd1);
          chk($sformatf("hold_flit[%0d]", i), 64'(f), 64'(pf[i]));
        end
        if (valid4[i] && ready4[i]) begin
          chk($sformatf("src[%0d]", i), 64'(f[7:4]), 64'(i));
          chk($sformatf("seq[%0d]", i), 64'(f[15:8]), 64'(seen[i]));
          chk($sformatf("upper[%0d]", i), 64'(f[31:16]), 64'd0);
          if (cur_mode == 2'd0)
            chk($sformatf("dst_ne_src[%0d]", i), 64'(f[3:0] != 4'(i)), 64'd1);
          else
            chk($sformatf("dst[%0d]", i), 64'(f[3:0]), 64'(exp_dst4(cur_mode, cur_fixed, i)));
          seen[i] = seen[i] + 1;
        end
        pf[i] = f;
      end
      pv  = valid4;
      phs = valid4 & ready4;
    end
    was_en = mon_en;
  end

  typedef struct {
    logic [1:0] mode;
    logic [3:0] fixed;
    logic [7:0] pkts;
    logic [3:0] gap;
    bit         rnd;
    int         exp_total;
  } vec_t;

  vec_t vt [5];

  task automatic run4(input vec_t v, input int idx);
    bit got;
    int sum;
    mode4 = v.mode; fixed4 = v.fixed; pkts4 = v.pkts; gap4 = v.gap;
    ready4 = '1;
    cur_mode = v.mode; cur_fixed = v.fixed;
    mon_en = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk($sformatf("v%0d_busy_run", idx), 64'(busy4), 64'd1);
    got = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      ready4 = v.rnd ? 16'($urandom) : 16'hFFFF;
      tick();
      if (done4) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_done_seen", idx), 64'(got), 64'd1);
    chk($sformatf("v%0d_total", idx), 64'(total4), 64'(v.exp_total));
    chk($sformatf("v%0d_busy_done", idx), 64'(busy4), 64'd0);
    mon_en = 1'b0;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d_count[%0d]", idx, i), 64'(seen[i]), 64'(v.pkts));
      sum += seen[i];
    end
    chk($sformatf("v%0d_hs_sum", idx), 64'(sum), 64'(v.exp_total));
    tick();
    chk($sformatf("v%0d_done_pulse", idx), 64'(done4), 64'd0);
    chk($sformatf("v%0d_valid_idle", idx), 64'(valid4), 64'd0);
  endtask

  initial begin
    int exp_tot;
    logic [3:0] exp_v;

    vt[0] = '{mode: 2'd2, fixed: 4'd0, pkts: 8'd1,   gap: 4'd0, rnd: 1'b0, exp_total: 16};
    vt[1] = '{mode: 2'd3, fixed: 4'd0, pkts: 8'd2,   gap: 4'd3, rnd: 1'b0, exp_total: 32};
    vt[2] = '{mode: 2'd1, fixed: 4'd9, pkts: 8'd2,   gap: 4'd1, rnd: 1'b1, exp_total: 32};
    vt[3] = '{mode: 2'd0, fixed: 4'd0, pkts: 8'd5,   gap: 4'd2, rnd: 1'b1, exp_total: 80};
    vt[4] = '{mode: 2'd0, fixed: 4'd0, pkts: 8'd255, gap: 4'd0, rnd: 1'b1, exp_total: 4080};

    rst2_n = 1'b0; start2 = 1'b0; mode2 = '0; fixed2 = '0; pkts2 = '0; gap2 = '0; ready2 = '1;
    rst4_n = 1'b0; start4 = 1'b0; mode4 = '0; fixed4 = '0; pkts4 = '0; gap4 = '0; ready4 = '1;
    cur_mode = '0; cur_fixed = '0;
    tick();
    tick();
    chk("rst2_valid", 64'(valid2), 64'd0);
    chk("rst2_flit", 64'(flit2[63:0]), 64'd0);
    chk("rst2_busy", 64'(busy2), 64'd0);
    chk("rst2_done", 64'(done2), 64'd0);
    chk("rst2_total", 64'(total2), 64'd0);
    chk("rst4_valid", 64'(valid4), 64'd0);
    chk("rst4_total", 64'(total4), 64'd0);
    rst2_n = 1'b1;
    rst4_n = 1'b1;
    tick();

    // 2x2 ring-next, 3 packets, gap 0, always ready; a start mid-run is ignored
    mode2 = 2'd3; pkts2 = 8'd3; gap2 = 4'd0; ready2 = 4'hF; start2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) start2 = 1'b0;
      if (k == 4) start2 = 1'b1;
      if (k == 5) start2 = 1'b0;
      exp_v   = (k == 2 || k == 4 || k == 6) ? 4'hF : 4'h0;
      exp_tot = (k >= 3) ? 4 * (((k - 1) / 2 > 3) ? 3 : (k - 1) / 2) : 0;
      chk($sformatf("A%0d_valid", k), 64'(valid2), 64'(exp_v));
      chk($sformatf("A%0d_busy", k), 64'(busy2), 64'(k <= 7));
      chk($sformatf("A%0d_done", k), 64'(done2), 64'(k == 8));
      chk($sformatf("A%0d_total", k), 64'(total2), 64'(exp_tot));
      if (exp_v != 4'h0) begin
        for (int i = 0; i < 4; i++)
          chk($sformatf("A%0d_flit[%0d]", k, i), 64'(flit2[i*32 +: 32]),
              64'(mk2((i + 1) % 4, i, (k - 2) / 2)));
      end
    end

    // 2x2 fixed destination (6 mod 4 = 2), channel 0 back-pressured for 10 cycles
    mode2 = 2'd1; fixed2 = 2'd2; pkts2 = 8'd1; gap2 = 4'd0; ready2 = 4'b1110; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    chk("B_valid_all", 64'(valid2), 64'hF);
    chk("B_flit0", 64'(flit2[31:0]), 64'(mk2(2, 0, 0)));
    chk("B_flit1", 64'(flit2[63:32]), 64'(mk2(2, 1, 0)));
    for (int k = 3; k <= 11; k++) begin
      tick();
      chk($sformatf("B%0d_valid", k), 64'(valid2), 64'h1);
      chk($sformatf("B%0d_flit0", k), 64'(flit2[31:0]), 64'(mk2(2, 0, 0)));
      if (k == 3) chk("B_total_others", 64'(total2), 64'd3);
    end
    ready2 = 4'hF;
    tick();
    chk("B_release_valid", 64'(valid2), 64'd0);
    chk("B_release_total", 64'(total2), 64'd4);
    tick();
    chk("B_done", 64'(done2), 64'd1);
    tick();
    chk("B_done_off", 64'(done2), 64'd0);

    // Zero packets: RUN for one cycle then DONE, no valid
    mode2 = 2'd3; pkts2 = 8'd0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("C_busy", 64'(busy2), 64'd1);
    chk("C_done_early", 64'(done2), 64'd0);
    chk("C_valid1", 64'(valid2), 64'd0);
    tick();
    chk("C_done", 64'(done2), 64'd1);
    chk("C_busy_off", 64'(busy2), 64'd0);
    chk("C_valid2", 64'(valid2), 64'd0);
    chk("C_total", 64'(total2), 64'd0);
    tick();
    chk("C_done_off", 64'(done2), 64'd0);

    // Reset mid-run with flits held, then a clean restart
    mode2 = 2'd3; pkts2 = 8'd3; gap2 = 4'd0; ready2 = 4'b0010; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    chk("D_valid", 64'(valid2), 64'hF);
    tick();
    chk("D_valid_held", 64'(valid2), 64'hD);
    chk("D_total", 64'(total2), 64'd1);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("D_rst_valid", 64'(valid2), 64'd0);
    chk("D_rst_flit", 64'(flit2[63:0]), 64'd0);
    chk("D_rst_busy", 64'(busy2), 64'd0);
    chk("D_rst_total", 64'(total2), 64'd0);
    tick();
    rst2_n = 1'b1;
    ready2 = 4'hF; pkts2 = 8'd1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    chk("D2_valid", 64'(valid2), 64'hF);
    chk("D2_flit0", 64'(flit2[31:0]), 64'(mk2(1, 0, 0)));
    chk("D2_flit1", 64'(flit2[63:32]), 64'(mk2(2, 1, 0)));
    tick();
    tick();
    chk("D2_done", 64'(done2), 64'd1);
    chk("D2_total", 64'(total2), 64'd4);

    // 4x4 table-driven runs
    for (int v = 0; v < 5; v++) run4(vt[v], v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
